// File: rtl/mips_muldiv_unit.sv
// Iterative MIPS HI/LO multiply/divide unit: shift-add MULT/MULTU, restoring DIV/DIVU, MTHI/MTLO.
// Optional MULDIV_FAST_MUL_EN: single-cycle MULT/MULTU; divide stays iterative.
module mips_muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_enable,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int unsigned W2 = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIXUP
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [W2-1:0]     acc_q, acc_d;
  logic [WIDTH-1:0]  mag_a_q, mag_a_d;
  logic [WIDTH-1:0]  mag_b_q, mag_b_d;
  logic              is_div_q, is_div_d;
  logic              neg_q, neg_d;
  logic              a_neg_q, a_neg_d;
  logic              b_zero_q, b_zero_d;
  logic [WIDTH-1:0]  hi_q, hi_d;
  logic [WIDTH-1:0]  lo_q, lo_d;
  logic              busy_q, busy_d;
  logic              upd_q, upd_d;
  logic              done_q, done_d;

  // Operand sign/magnitude extraction for the incoming request
  logic              sign_a, sign_b;
  logic [WIDTH-1:0]  abs_a, abs_b;

  assign sign_a = ~op[0] & a[WIDTH-1];
  assign sign_b = ~op[0] & b[WIDTH-1];
  assign abs_a  = sign_a ? (~a + WIDTH'(1)) : a;
  assign abs_b  = sign_b ? (~b + WIDTH'(1)) : b;

`ifdef MULDIV_FAST_MUL_EN
  logic [W2-1:0] fast_prod;
  assign fast_prod = W2'(abs_a) * W2'(abs_b);
`endif

  // One shift-add multiply step: conditionally add multiplicand to upper half, shift right
  logic [WIDTH:0] mul_sum;
  assign mul_sum = {1'b0, acc_q[W2-1:WIDTH]} + (acc_q[0] ? {1'b0, mag_a_q} : '0);

  // One restoring divide step: shift in next dividend bit, subtract divisor if it fits
  logic [WIDTH:0]   div_rem;
  logic [WIDTH:0]   div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] div_new_rem;

  assign div_rem     = {acc_q[W2-1:WIDTH], acc_q[WIDTH-1]};
  assign div_diff    = div_rem - {1'b0, mag_b_q};
  assign div_ge      = (div_rem >= {1'b0, mag_b_q});
  assign div_new_rem = div_ge ? div_diff[WIDTH-1:0] : div_rem[WIDTH-1:0];

  // Sign correction and special cases applied in FIXUP
  logic [W2-1:0]    mul_res;
  logic [WIDTH-1:0] quo, rem;
  logic [WIDTH-1:0] fix_hi, fix_lo;

  assign mul_res = neg_q ? (~acc_q + W2'(1)) : acc_q;
  assign quo     = acc_q[WIDTH-1:0];
  assign rem     = acc_q[W2-1:WIDTH];

  always_comb begin
    fix_hi = mul_res[W2-1:WIDTH];
    fix_lo = mul_res[WIDTH-1:0];
    if (is_div_q) begin
      fix_hi = a_neg_q ? (~rem + WIDTH'(1)) : rem;
      fix_lo = neg_q ? (~quo + WIDTH'(1)) : quo;
      if (b_zero_q) fix_lo = '1;
    end
  end

  // Next-state and datapath updates
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mag_a_d  = mag_a_q;
    mag_b_d  = mag_b_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    a_neg_d  = a_neg_q;
    b_zero_d = b_zero_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    busy_d   = busy_q;
    upd_d    = 1'b0;
    done_d   = upd_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          unique case (op)
            OP_MULT, OP_MULTU: begin
              mag_a_d  = abs_a;
              mag_b_d  = abs_b;
              neg_d    = sign_a ^ sign_b;
              a_neg_d  = sign_a;
              b_zero_d = 1'b0;
              is_div_d = 1'b0;
              cnt_d    = '0;
              busy_d   = 1'b1;
`ifdef MULDIV_FAST_MUL_EN
              acc_d    = fast_prod;
              state_d  = S_FIXUP;
`else
              acc_d    = {WIDTH'(0), abs_b};
              state_d  = S_MUL;
`endif
            end
            OP_DIV, OP_DIVU: begin
              mag_a_d  = abs_a;
              mag_b_d  = abs_b;
              neg_d    = sign_a ^ sign_b;
              a_neg_d  = sign_a;
              b_zero_d = (b == '0);
              is_div_d = 1'b1;
              cnt_d    = '0;
              busy_d   = 1'b1;
              acc_d    = {WIDTH'(0), abs_a};
              state_d  = S_DIV;
            end
            OP_MTHI: begin
              hi_d  = a;
              upd_d = 1'b1;
            end
            OP_MTLO: begin
              lo_d  = a;
              upd_d = 1'b1;
            end
            default: ;
          endcase
        end
      end
      S_MUL: begin
        acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIXUP;
      end
      S_DIV: begin
        acc_d = {div_new_rem, acc_q[WIDTH-2:0], div_ge};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIXUP;
      end
      S_FIXUP: begin
        hi_d    = fix_hi;
        lo_d    = fix_lo;
        busy_d  = 1'b0;
        upd_d   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register; clk_enable low freezes everything
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mag_a_q  <= '0;
      mag_b_q  <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      a_neg_q  <= 1'b0;
      b_zero_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      upd_q    <= 1'b0;
      done_q   <= 1'b0;
    end else if (clk_enable) begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mag_a_q  <= mag_a_d;
      mag_b_q  <= mag_b_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      a_neg_q  <= a_neg_d;
      b_zero_q <= b_zero_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      upd_q    <= upd_d;
      done_q   <= done_d;
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Directed self-checking bench for mips_muldiv_unit at WIDTH=32.
// Honors MULDIV_FAST_MUL_EN for the expected multiply latency.
module tb_mips_muldiv_unit;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
  localparam logic [2:0] OP_RSVD  = 3'b110;

  // Samples from the start edge to the done pulse, and busy-high samples
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_DONE_N = 2;
  localparam int MUL_BUSY_N = 1;
`else
  localparam int MUL_DONE_N = 34;
  localparam int MUL_BUSY_N = 33;
`endif
  localparam int DIV_DONE_N = 34;
  localparam int DIV_BUSY_N = 33;

  logic        clk;
  logic        reset;
  logic        clk_enable;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;

  int errors = 0;
  int checks = 0;

  mips_muldiv_unit #(.WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .clk_enable (clk_enable),
    .start      (start),
    .op         (op),
    .a          (a),
    .b          (b),
    .hi         (hi),
    .lo         (lo),
    .busy       (busy),
    .done       (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Bounded wait for done; n counts negedges after the start edge
  task automatic wait_done(output int n, output int bc);
    n  = 0;
    bc = (busy === 1'b1) ? 1 : 0;
    while (done !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
      if (busy === 1'b1) bc++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; clk_enable = 1'b1; start = 1'b0; op = 3'b000; a = '0; b = '0;
    #2;
    checks++; if (hi !== 32'h0)  begin errors++; $display("FAIL reset_hi got %h want %h", hi, 32'h0); end
    checks++; if (lo !== 32'h0)  begin errors++; $display("FAIL reset_lo got %h want %h", lo, 32'h0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_multu_max;
    int n, bc;
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(n, bc);
    checks++; if (hi !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_max_hi got %h want %h", hi, 32'hFFFF_FFFE); end
    checks++; if (lo !== 32'h0000_0001) begin errors++; $display("FAIL multu_max_lo got %h want %h", lo, 32'h1); end
    checks++; if (n != MUL_DONE_N) begin errors++; $display("FAIL multu_latency got %0d want %0d", n, MUL_DONE_N); end
    checks++; if (bc != MUL_BUSY_N) begin errors++; $display("FAIL multu_busy_cycles got %0d want %0d", bc, MUL_BUSY_N); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL multu_done_pulse got %b want 0", done); end
  endtask

  task automatic test_mult_signed;
    int n, bc;
    issue(OP_MULT, 32'hFFFF_FFFD, 32'd7);
    wait_done(n, bc);
    checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_m3x7_hi got %h want %h", hi, 32'hFFFF_FFFF); end
    checks++; if (lo !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mult_m3x7_lo got %h want %h", lo, 32'hFFFF_FFEB); end
    checks++; if (n != MUL_DONE_N) begin errors++; $display("FAIL mult_latency got %0d want %0d", n, MUL_DONE_N); end
    issue(OP_MULT, 32'hFFFF_FFFB, 32'hFFFF_FFFA);
    wait_done(n, bc);
    checks++; if (hi !== 32'h0)  begin errors++; $display("FAIL mult_m5xm6_hi got %h want %h", hi, 32'h0); end
    checks++; if (lo !== 32'h1E) begin errors++; $display("FAIL mult_m5xm6_lo got %h want %h", lo, 32'h1E); end
  endtask

  task automatic test_div;
    int n, bc;
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_done(n, bc);
    checks++; if (lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_m7_2_lo got %h want %h", lo, 32'hFFFF_FFFD); end
    checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_m7_2_hi got %h want %h", hi, 32'hFFFF_FFFF); end
    checks++; if (n != DIV_DONE_N) begin errors++; $display("FAIL div_latency got %0d want %0d", n, DIV_DONE_N); end
    checks++; if (bc != DIV_BUSY_N) begin errors++; $display("FAIL div_busy_cycles got %0d want %0d", bc, DIV_BUSY_N); end
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(n, bc);
    checks++; if (lo !== 32'h8000_0000) begin errors++; $display("FAIL div_ovf_lo got %h want %h", lo, 32'h8000_0000); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL div_ovf_hi got %h want %h", hi, 32'h0); end
    issue(OP_DIV, 32'd7, 32'hFFFF_FFFE);
    wait_done(n, bc);
    checks++; if (lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_7_m2_lo got %h want %h", lo, 32'hFFFF_FFFD); end
    checks++; if (hi !== 32'h1) begin errors++; $display("FAIL div_7_m2_hi got %h want %h", hi, 32'h1); end
    issue(OP_DIVU, 32'd100, 32'd7);
    wait_done(n, bc);
    checks++; if (lo !== 32'd14) begin errors++; $display("FAIL divu_100_7_lo got %h want %h", lo, 32'd14); end
    checks++; if (hi !== 32'd2)  begin errors++; $display("FAIL divu_100_7_hi got %h want %h", hi, 32'd2); end
  endtask

  task automatic test_div_zero;
    int n, bc;
    issue(OP_DIVU, 32'd100, 32'd0);
    wait_done(n, bc);
    checks++; if (lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divu_zero_lo got %h want %h", lo, 32'hFFFF_FFFF); end
    checks++; if (hi !== 32'h64) begin errors++; $display("FAIL divu_zero_hi got %h want %h", hi, 32'h64); end
    checks++; if (n != DIV_DONE_N) begin errors++; $display("FAIL divu_zero_latency got %0d want %0d", n, DIV_DONE_N); end
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd0);
    wait_done(n, bc);
    checks++; if (lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_zero_lo got %h want %h", lo, 32'hFFFF_FFFF); end
    checks++; if (hi !== 32'hFFFF_FFF9) begin errors++; $display("FAIL div_zero_hi got %h want %h", hi, 32'hFFFF_FFF9); end
  endtask

  task automatic test_reserved;
    issue(OP_MTHI, 32'hAAAA, 32'h0);
    @(negedge clk);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL mthi_done got %b want 1", done); end
    issue(OP_MTLO, 32'hBBBB, 32'h0);
    @(negedge clk);
    issue(OP_RSVD, 32'hDEAD, 32'hBEEF);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rsvd_busy got %b want 0", busy); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rsvd_done got %b want 0", done); end
    checks++; if (hi !== 32'hAAAA) begin errors++; $display("FAIL rsvd_hi got %h want %h", hi, 32'hAAAA); end
    checks++; if (lo !== 32'hBBBB) begin errors++; $display("FAIL rsvd_lo got %h want %h", lo, 32'hBBBB); end
  endtask

  task automatic test_busy_ignore_freeze;
    int n;
    logic [31:0] exp_hi, exp_lo;
`ifdef MULDIV_FAST_MUL_EN
    issue(OP_DIVU, 32'h1234_5678, 32'h10);
    exp_hi = 32'h8; exp_lo = 32'h0123_4567;
`else
    issue(OP_MULTU, 32'h1234_5678, 32'h10);
    exp_hi = 32'h1; exp_lo = 32'h2345_6780;
`endif
    n = 0;
    while (done !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
      if (n == 6) begin
        checks++; if (hi !== 32'hAAAA) begin errors++; $display("FAIL inflight_hi_hold got %h want %h", hi, 32'hAAAA); end
      end
      if (n == 15) begin
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL frozen_busy got %b want 1", busy); end
      end
      if (n == 4) begin start = 1'b1; op = OP_MTHI; a = 32'h1234; end
      if (n == 5) start = 1'b0;
      if (n == 10) clk_enable = 1'b0;
      if (n == 20) clk_enable = 1'b1;
    end
    checks++; if (n != 44) begin errors++; $display("FAIL freeze_latency got %0d want %0d", n, 44); end
    checks++; if (hi !== exp_hi) begin errors++; $display("FAIL ignore_hi got %h want %h", hi, exp_hi); end
    checks++; if (lo !== exp_lo) begin errors++; $display("FAIL ignore_lo got %h want %h", lo, exp_lo); end
  endtask

  task automatic test_done_stretch;
    issue(OP_MTLO, 32'h77, 32'h0);
    checks++; if (lo !== 32'h77) begin errors++; $display("FAIL mtlo_lo got %h want %h", lo, 32'h77); end
    @(negedge clk);
    clk_enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL done_stretch_%0d got %b want 1", i, done); end
    end
    clk_enable = 1'b1;
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_stretch_end got %b want 0", done); end
  endtask

  task automatic test_reset_mid;
    issue(OP_DIVU, 32'd100, 32'd7);
    repeat (10) @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (hi !== 32'h0)  begin errors++; $display("FAIL rstmid_hi got %h want %h", hi, 32'h0); end
    checks++; if (lo !== 32'h0)  begin errors++; $display("FAIL rstmid_lo got %h want %h", lo, 32'h0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rstmid_done got %b want 0", done); end
    @(negedge clk);
    reset = 1'b1; start = 1'b1; op = OP_MTLO; a = 32'h55;
    @(negedge clk);
    start = 1'b0;
    checks++; if (lo !== 32'h55) begin errors++; $display("FAIL post_rst_mtlo got %h want %h", lo, 32'h55); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_rst_busy got %b want 0", busy); end
    @(negedge clk);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL post_rst_done got %b want 1", done); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL post_rst_done_end got %b want 0", done); end
  endtask

  initial begin
    test_reset();
    test_multu_max();
    test_mult_signed();
    test_div();
    test_div_zero();
    test_reserved();
    test_busy_ignore_freeze();
    test_done_stretch();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
